// File: rtl/femto_pll_sequencer.sv
// femto_pll_sequencer: pulses the femtoPLL reset, waits for a stable lock, then releases system reset.
// Define FEMTO_PLL_SEQ_RETRY_LIMIT_EN to enable the MAX_RETRIES limit and the terminal FAIL state.
module femto_pll_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 262144,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic [2:0] state,
  output logic [3:0] retries,
  output logic       fail
);

  localparam int MAX_AB = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
`ifdef FEMTO_PLL_SEQ_RETRY_LIMIT_EN
  localparam logic [2:0] ST_FAIL      = 3'd4;
`endif

  logic [1:0]    sync;
  logic          locked_s;
  logic [2:0]    st;
  logic [2:0]    nxt;
  logic [CW-1:0] cnt;
  logic          timeout;
  logic [3:0]    retries_inc;

  // pll_locked comes from the PLL's own domain, so it is double-flopped before use
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pll_locked};
    end
  end

  assign locked_s    = sync[1];
  assign retries_inc = (retries == 4'hf) ? 4'hf : retries + 4'd1;

  always_comb begin
    nxt     = st;
    timeout = 1'b0;
    case (st)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // a lock arriving on the timeout cycle takes priority over the timeout
        if (locked_s) begin
          nxt = ST_STABLE;
        end else if (cnt == LOCK_LAST) begin
          timeout = 1'b1;
`ifdef FEMTO_PLL_SEQ_RETRY_LIMIT_EN
          nxt = (32'(retries_inc) == MAX_RETRIES) ? ST_FAIL : ST_PLL_RST;
`else
          nxt = ST_PLL_RST;
`endif
        end
      end
      ST_STABLE: begin
        if (!locked_s) nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST) nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) nxt = ST_PLL_RST;
      end
`ifdef FEMTO_PLL_SEQ_RETRY_LIMIT_EN
      ST_FAIL: nxt = ST_FAIL;
`endif
      default: nxt = ST_PLL_RST;
    endcase
  end

  // cnt measures time spent in the current state and restarts on every transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= ST_PLL_RST;
      cnt     <= '0;
      retries <= 4'd0;
    end else begin
      st <= nxt;
      if (nxt != st) cnt <= '0;
      else cnt <= cnt + CW'(1);
      if (timeout) retries <= retries_inc;
    end
  end

  assign state     = st;
  assign sys_reset = (st != ST_RUN);
  assign ready     = (st == ST_RUN);

`ifdef FEMTO_PLL_SEQ_RETRY_LIMIT_EN
  assign pll_reset = (st == ST_PLL_RST) || (st == ST_FAIL);
  assign fail      = (st == ST_FAIL);
`else
  // MAX_RETRIES has no effect without the retry limit
  logic unused_max_retries;
  assign unused_max_retries = ^32'(MAX_RETRIES);
  assign pll_reset = (st == ST_PLL_RST);
  assign fail      = 1'b0;
`endif

endmodule

// File: tb/tb_femto_pll_sequencer.sv
// tb_femto_pll_sequencer: directed timeline checks plus randomized lock traffic against a behavioural model.
// Honours FEMTO_PLL_SEQ_RETRY_LIMIT_EN the same way the design does.
module tb_femto_pll_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int STABLE_CYCLES = 8;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int MAX_RETRIES   = 2;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic [2:0] state;
  logic [3:0] retries;
  logic       fail;

  int assertions = 0;
  int failures   = 0;

  // behavioural model: phase name, time spent in that phase, timeout tally, input history
  int   m_phase   = 0;
  int   m_elapsed = 0;
  int   m_retries = 0;
  logic hist[$];

  femto_pll_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .pll_reset (pll_reset),
    .sys_reset (sys_reset),
    .ready     (ready),
    .state     (state),
    .retries   (retries),
    .fail      (fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lock_val, input logic reset_val);
    pll_locked = lock_val;
    reset      = reset_val;
  endtask

  // advance n clock edges, landing 3 time units after the last edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic waitState(input int s, input int limit);
    int n;
    n = 0;
    while (state !== 3'(s) && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput("wait_state", int'(state), s);
  endtask

  // one clock of the model: the FSM sees the lock input as it was two edges ago
  task automatic modelStep(input logic din);
    logic seen;
    int   next_phase;
    hist.push_back(din);
    seen = (hist.size() > 2) ? hist[hist.size() - 3] : 1'b0;
    next_phase = m_phase;
    if (m_phase == 0 && m_elapsed == RST_CYCLES - 1) next_phase = 1;
    else if (m_phase == 1 && seen) next_phase = 2;
    else if (m_phase == 1 && m_elapsed == LOCK_TIMEOUT - 1) begin
      m_retries = (m_retries < 15) ? m_retries + 1 : 15;
      next_phase = 0;
`ifdef FEMTO_PLL_SEQ_RETRY_LIMIT_EN
      if (m_retries == MAX_RETRIES) next_phase = 4;
`endif
    end
    else if (m_phase == 2 && !seen) next_phase = 1;
    else if (m_phase == 2 && m_elapsed == STABLE_CYCLES - 1) next_phase = 3;
    else if (m_phase == 3 && !seen) next_phase = 0;
    m_elapsed = (next_phase == m_phase) ? m_elapsed + 1 : 0;
    m_phase   = next_phase;
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase   = 0;
        m_elapsed = 0;
        m_retries = 0;
        hist.delete();
      end else begin
        modelStep(pll_locked);
      end
    end
  end

  // compare process: every falling edge, all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_state", int'(state), m_phase);
      checkOutput("model_retries", int'(retries), m_retries);
      checkOutput("model_pll_reset", int'(pll_reset), int'(m_phase == 0 || m_phase == 4));
      checkOutput("model_sys_reset", int'(sys_reset), int'(m_phase != 3));
      checkOutput("model_ready", int'(ready), int'(m_phase == 3));
      checkOutput("model_fail", int'(fail), int'(m_phase == 4));
    end
  end

  initial begin
    int run_left;
    logic lk;
    applyStimulus(1'b0, 1'b1);
    tick(2);
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_pll_reset", int'(pll_reset), 1);
    checkOutput("reset_sys_reset", int'(sys_reset), 1);
    checkOutput("reset_ready", int'(ready), 0);
    checkOutput("reset_fail", int'(fail), 0);

    // constant lock: release timeline, then a lock drop while running
    applyStimulus(1'b1, 1'b0);
    tick(3);
    checkOutput("e3_pll_reset", int'(pll_reset), 1);
    tick(1);
    checkOutput("e4_state", int'(state), 1);
    checkOutput("e4_pll_reset", int'(pll_reset), 0);
    tick(1);
    checkOutput("e5_state", int'(state), 2);
    tick(7);
    checkOutput("e12_ready", int'(ready), 0);
    tick(1);
    checkOutput("e13_ready", int'(ready), 1);
    checkOutput("e13_sys_reset", int'(sys_reset), 0);
    checkOutput("e13_retries", int'(retries), 0);
    tick(6);
    applyStimulus(1'b0, 1'b0);
    tick(2);
    checkOutput("e21_ready", int'(ready), 1);
    tick(1);
    checkOutput("e22_sys_reset", int'(sys_reset), 1);
    checkOutput("e22_ready", int'(ready), 0);
    checkOutput("e22_pll_reset", int'(pll_reset), 1);
    applyStimulus(1'b1, 1'b0);
    tick(3);
    checkOutput("e25_pll_reset", int'(pll_reset), 1);
    tick(1);
    checkOutput("e26_pll_reset", int'(pll_reset), 0);
    tick(8);
    checkOutput("e34_ready", int'(ready), 0);
    tick(1);
    checkOutput("e35_ready", int'(ready), 1);

    // lock appearing exactly on the timeout cycle must win
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    tick(33);
    applyStimulus(1'b1, 1'b0);
    tick(2);
    checkOutput("race_e35_state", int'(state), 1);
    tick(1);
    checkOutput("race_e36_state", int'(state), 2);
    checkOutput("race_e36_retries", int'(retries), 0);

    // never locked: timeouts at edges 36 and 72
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    tick(35);
    checkOutput("e35_state", int'(state), 1);
    tick(1);
    checkOutput("e36_state", int'(state), 0);
    checkOutput("e36_retries", int'(retries), 1);
    tick(36);
    checkOutput("e72_retries", int'(retries), 2);
`ifdef FEMTO_PLL_SEQ_RETRY_LIMIT_EN
    checkOutput("e72_state", int'(state), 4);
    checkOutput("e72_fail", int'(fail), 1);
    checkOutput("e72_pll_reset", int'(pll_reset), 1);
    tick(100);
    checkOutput("fail_hold_state", int'(state), 4);
    checkOutput("fail_hold_fail", int'(fail), 1);
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0);
`else
    checkOutput("e72_state", int'(state), 0);
    checkOutput("e72_fail", int'(fail), 0);
    applyStimulus(1'b1, 1'b0);
`endif

    // asynchronous reset between edges while in STABLE
    waitState(2, 40);
    #3;
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("async_state", int'(state), 0);
    checkOutput("async_pll_reset", int'(pll_reset), 1);
    checkOutput("async_sys_reset", int'(sys_reset), 1);
    checkOutput("async_retries", int'(retries), 0);
    checkOutput("async_ready", int'(ready), 0);
    tick(1);

    // long lock loss: retries saturation (or FAIL with the limit)
    applyStimulus(1'b0, 1'b0);
    tick(600);
`ifdef FEMTO_PLL_SEQ_RETRY_LIMIT_EN
    checkOutput("sat_state", int'(state), 4);
    checkOutput("sat_retries", int'(retries), 2);
`else
    checkOutput("sat_retries", int'(retries), 15);
    checkOutput("sat_fail", int'(fail), 0);
`endif

    // randomized lock traffic with occasional resets
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    lk = 1'b0;
    run_left = 0;
    for (int i = 0; i < 5000; i++) begin
      if (run_left == 0) begin
        lk = ~lk;
        run_left = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 20);
      end
      run_left--;
      applyStimulus(lk, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
      tick(1);
    end
    applyStimulus(lk, 1'b0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
